crc_check: RTL and testbench

CRC_CHECK -- requirements
Module: crc_check

---
 rtl/usb_crc_pkg.sv | 25 ++
 rtl/usb_crc_lfsr.sv | 31 +++
 rtl/crc_check.sv | 116 +++++++++++
 tb/tb_crc_check.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the USB receive-side CRC checker.
package usb_crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REPORT
  } state_t;

  localparam int CRC5_WIDTH  = 5;
  localparam int CRC16_WIDTH = 16;

  localparam logic [CRC5_WIDTH-1:0]  CRC5_POLY      = 5'b00101;
  localparam logic [CRC5_WIDTH-1:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [CRC16_WIDTH-1:0] CRC16_POLY     = 16'h8005;
  localparam logic [CRC16_WIDTH-1:0] CRC16_RESIDUAL = 16'h800D;

  localparam int COUNT_WIDTH = 14;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  localparam count_t COUNT_MAX      = '1;
  localparam count_t CRC5_TOKEN_LEN = 14'd16;
  localparam count_t CRC16_MIN_LEN  = 14'd16;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC shift register; seed restarts from all-ones and absorbs the current bit.
module usb_crc_lfsr #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             shift,
  input  logic             in,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] r_next;
  logic             fb;

  always_comb begin
    base   = seed ? '1 : r;
    fb     = base[WIDTH-1] ^ in;
    r_next = {base[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & POLY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r <= '1;
    else if (seed || shift)
      r <= r_next;
  end

endmodule

// File: rtl/crc_check.sv
// USB packet CRC checker: serial residual check with a one-cycle verdict after the last CRC bit.
// Optional CRC16 data-packet support is enabled by defining USB_CRC16_EN.
module crc_check
  import usb_crc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic stream_begin,
  input  logic stream_done,
  input  logic halt_stream,
  input  logic crc16_sel,
  output logic busy,
  output logic crc_done,
  output logic crc_ok,
  output logic crc_err
);

  state_t state, state_next;
  count_t count, count_next;
  logic   ok_q, ok_next, err_q, err_next;
  logic   accepted, begin_acc, done_acc, shift, pass;
  logic [CRC5_WIDTH-1:0] r5;

  assign accepted  = !halt_stream;
  assign begin_acc = accepted && stream_begin;
  assign done_acc  = accepted && stream_done;
  assign shift     = accepted && (state == CHECK);

  usb_crc_lfsr #(.WIDTH(CRC5_WIDTH), .POLY(CRC5_POLY)) u_crc5 (
    .clk   (clk),
    .rst   (rst),
    .seed  (begin_acc),
    .shift (shift),
    .in    (in),
    .r     (r5)
  );

`ifdef USB_CRC16_EN
  logic                   is16;
  logic [CRC16_WIDTH-1:0] r16;

  usb_crc_lfsr #(.WIDTH(CRC16_WIDTH), .POLY(CRC16_POLY)) u_crc16 (
    .clk   (clk),
    .rst   (rst),
    .seed  (begin_acc),
    .shift (shift),
    .in    (in),
    .r     (r16)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      is16 <= 1'b0;
    else if (begin_acc)
      is16 <= crc16_sel;
  end

  // Data packets must be whole bytes and at least as long as the CRC field.
  assign pass = is16 ? ((r16 == CRC16_RESIDUAL) && (count >= CRC16_MIN_LEN) && (count[2:0] == 3'b000))
                     : ((r5 == CRC5_RESIDUAL) && (count == CRC5_TOKEN_LEN));
`else
  logic unused_crc16_sel;
  assign unused_crc16_sel = crc16_sel;
  assign pass = (r5 == CRC5_RESIDUAL) && (count == CRC5_TOKEN_LEN);
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    ok_next    = ok_q;
    err_next   = err_q;
    unique case (state)
      CHECK: begin
        if (accepted) begin
          count_next = (count == COUNT_MAX) ? count : count + count_t'(1);
          if (done_acc)
            state_next = REPORT;
        end
      end
      REPORT: begin
        ok_next    = pass;
        err_next   = !pass;
        state_next = IDLE;
      end
      default: ;
    endcase
    // A new packet start overrides everything, including an in-flight packet.
    if (begin_acc) begin
      state_next = done_acc ? REPORT : CHECK;
      count_next = count_t'(1);
      ok_next    = 1'b0;
      err_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      ok_q  <= ok_next;
      err_q <= err_next;
    end
  end

  assign busy     = (state == CHECK);
  assign crc_done = (state == REPORT);
  assign crc_ok   = crc_done ? pass  : ok_q;
  assign crc_err  = crc_done ? !pass : err_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: vector table of whole packets plus halt, restart and reset sequences.
module tb_crc_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in = 1'b0;
  logic stream_begin = 1'b0;
  logic stream_done = 1'b0;
  logic halt_stream = 1'b0;
  logic crc16_sel = 1'b0;
  logic busy, crc_done, crc_ok, crc_err;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // addr=0 endp=0 token: eleven zeros then CRC5 5'b00010 sent LSB-first (bit i = i-th bit on the wire)
  localparam logic [31:0] TOKEN = 32'h0000_1000;

  typedef struct {
    logic [31:0] bits;
    int          len;
    logic        sel;
    logic        exp_ok;
  } vec_t;

  crc_check dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .stream_begin (stream_begin),
    .stream_done  (stream_done),
    .halt_stream  (halt_stream),
    .crc16_sel    (crc16_sel),
    .busy         (busy),
    .crc_done     (crc_done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err)
  );

  always #5 clk = ~clk;

  task applyStimulus(input logic b, input logic sb, input logic sd, input logic h, input logic sel);
    in           = b;
    stream_begin = sb;
    stream_done  = sd;
    halt_stream  = h;
    crc16_sel    = sel;
    @(posedge clk);
    #1;
    if (crc_done === 1'b1) done_seen++;
  endtask

  task checkOutput(input string name, input logic [3:0] expected);
    logic [3:0] actual;
    actual = {busy, crc_done, crc_ok, crc_err};
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: busy/done/ok/err got %b expected %b", name, actual, expected);
    end
  endtask

  task checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task sendPacket(input logic [31:0] bits, input int len, input logic sel, input logic exp_ok, input string name);
    for (int i = 0; i < len; i++) begin
      applyStimulus(bits[i], i == 0, i == len - 1, 1'b0, sel);
      if (i == 0 && len > 1) checkOutput({name, " start"}, 4'b1000);
    end
    checkOutput({name, " verdict"}, {2'b01, exp_ok, !exp_ok});
  endtask

  initial begin
    vec_t vecs[$];
    int   d0;

    vecs.push_back('{TOKEN,              16, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_1008,      16, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_9000,      16, 1'b0, 1'b0});
    vecs.push_back('{TOKEN,              15, 1'b0, 1'b0});
    vecs.push_back('{TOKEN,              17, 1'b0, 1'b0});
`ifdef USB_CRC16_EN
    vecs.push_back('{32'h0000_0000,      16, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0000,      15, 1'b1, 1'b0});
`else
    vecs.push_back('{TOKEN,              16, 1'b1, 1'b1});
`endif
    vecs.push_back('{32'h0000_0000,       1, 1'b0, 1'b0});

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle after reset", 4'b0000);

    // Back-to-back packets: each new start lands in the previous REPORT cycle.
    foreach (vecs[k])
      sendPacket(vecs[k].bits, vecs[k].len, vecs[k].sel, vecs[k].exp_ok, $sformatf("vec%0d", k));

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("verdict held", 4'b0001);
    d0 = done_seen;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("done in idle ignored", 4'b0001);
    checkCount("done in idle no pulse", done_seen - d0, 0);

    // Three halted cycles, one carrying a gated stream_begin and two carrying stream_done.
    for (int i = 0; i < 6; i++) applyStimulus(TOKEN[i], i == 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("halt gates begin", 4'b1000);
    for (int i = 6; i < 15; i++) applyStimulus(TOKEN[i], 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(TOKEN[15], 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("halt gates done 1", 4'b1000);
    applyStimulus(TOKEN[15], 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("halt gates done 2", 4'b1000);
    applyStimulus(TOKEN[15], 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("halted token verdict", 4'b0110);

    // Restart at bit 7 of a token: only the second packet may report.
    d0 = done_seen;
    for (int i = 0; i < 7; i++) applyStimulus(TOKEN[i], i == 0, 1'b0, 1'b0, 1'b0);
    sendPacket(TOKEN, 16, 1'b0, 1'b1, "restart token");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCount("restart single done", done_seen - d0, 1);

    // Reset at bit 9 discards the packet silently.
    for (int i = 0; i < 9; i++) applyStimulus(TOKEN[i], i == 0, 1'b0, 1'b0, 1'b0);
    checkOutput("before mid reset", 4'b1000);
    d0 = done_seen;
    rst = 1'b1;
    #2;
    checkOutput("async mid reset", 4'b0000);
    applyStimulus(TOKEN[9], 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("after mid reset", 4'b0000);
    checkCount("mid reset no done", done_seen - d0, 0);
    sendPacket(TOKEN, 16, 1'b0, 1'b1, "token after reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("final hold", 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
